// File: rtl/r22sdf_pkg.sv
// rtl/r22sdf_pkg.sv - shared types and helpers for the R2^2SDF reorder buffer
//
// Contents:
//   wr_state_e : write-side FSM state (IDLE, FILL, STREAM)
//   clog2      : constant ceil(log2) helper for address widths
//   bitrev     : reverse the low aw bits of a value (upper bits return 0)
package r22sdf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } wr_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Shift bits out of the LSB of value and into the LSB of the result,
  // so after aw steps the low aw bits come out mirrored.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int aw);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    v = value;
    for (int i = 0; i < 32; i++) begin
      if (i < aw) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/r22sdf_dpram.sv
// rtl/r22sdf_dpram.sv - simple dual-port RAM, one write port, one registered read port
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (clears the read register only)
//   we    : write enable;  waddr / wdata : write address / data
//   re    : read enable;   raddr : read address
//   rdata : read data, one cycle after re
module r22sdf_dpram
  import r22sdf_pkg::*;
#(
  parameter int depth = 32,
  parameter int width = 32,
  localparam int aw = clog2(depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             re,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register is reset so an unregistered output path still
  // presents zeros straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/r22sdf_reorder.sv
// rtl/r22sdf_reorder.sv - ping-pong reorder buffer, bit-reversed FFT output to natural order
//
// Ports:
//   sys_clk, sys_nrst     : clock (rising edge), asynchronous active-low reset
//   sys_en                : global enable; 0 freezes all state
//   din_r, din_i          : input sample, bit-reversed order
//   din_vld, din_sof      : sample valid, first sample of frame
//   dout_r, dout_i        : natural-order bin
//   dout_vld, dout_sof    : bin valid, bin 0 of a frame
//   dout_idx              : bin index
//   err_sof, err_cnt      : resync pulse and saturating resync count
//                           (only with R22SDF_REORDER_ERR_EN defined)
module r22sdf_reorder
  import r22sdf_pkg::*;
#(
  parameter int data_resolution = 16,
  parameter int fft_length      = 16,
  parameter bit ff_out_en       = 1'b1,
  localparam int aw = clog2(fft_length)
) (
  input  logic                       sys_clk,
  input  logic                       sys_nrst,
  input  logic                       sys_en,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  input  logic                       din_vld,
  input  logic                       din_sof,
  output logic [data_resolution-1:0] dout_r,
  output logic [data_resolution-1:0] dout_i,
  output logic                       dout_vld,
  output logic                       dout_sof,
  output logic [aw-1:0]              dout_idx
`ifdef R22SDF_REORDER_ERR_EN
  ,
  output logic                       err_sof,
  output logic [7:0]                 err_cnt
`endif
);

  localparam int dw = 2 * data_resolution;
  localparam logic [aw-1:0] cnt_last = aw'(fft_length - 1);

  wr_state_e       state_q, state_d;
  logic [aw-1:0]   wr_cnt_q, wr_cnt_d;
  logic            wr_bank_q, wr_bank_d;
  logic [aw-1:0]   wr_cnt_rev;
  logic            wr_acc;
  logic            ram_we;
  logic [aw:0]     ram_waddr;
  logic            rd_start;

  logic            rd_active_q;
  logic            rd_bank_q;
  logic [aw-1:0]   rd_cnt_q;
  logic            ram_re;
  logic [dw-1:0]   ram_rdata;

  logic            vld1_q, sof1_q;
  logic [aw-1:0]   idx1_q;

  assign wr_acc     = sys_en & din_vld;
  assign wr_cnt_rev = aw'(bitrev(32'(wr_cnt_q), aw));

  // ---------------- write side ----------------
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    ram_we    = 1'b0;
    ram_waddr = {wr_bank_q, wr_cnt_rev};
    rd_start  = 1'b0;
    if (wr_acc) begin
      case (state_q)
        IDLE: begin
          if (din_sof) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
            wr_bank_d = 1'b0;
            wr_cnt_d  = aw'(1);
            state_d   = FILL;
          end
        end
        FILL, STREAM: begin
          ram_we = 1'b1;
          if (din_sof && (wr_cnt_q != '0)) begin
            // Resync: restart the current bank; bitrev(0) is address 0.
            ram_waddr = {wr_bank_q, {aw{1'b0}}};
            wr_cnt_d  = aw'(1);
          end else if (wr_cnt_q == cnt_last) begin
            wr_cnt_d  = '0;
            wr_bank_d = ~wr_bank_q;
            rd_start  = 1'b1;
            state_d   = STREAM;
          end else begin
            wr_cnt_d  = wr_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
    end
  end

  // ---------------- read side ----------------
  // rd_start takes priority over the final read of the previous bank, so
  // back-to-back frames read out with no idle cycle between them.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rd_active_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
    end else if (sys_en) begin
      if (rd_start) begin
        rd_active_q <= 1'b1;
        rd_bank_q   <= wr_bank_q;
        rd_cnt_q    <= '0;
      end else if (rd_active_q) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        if (rd_cnt_q == cnt_last) rd_active_q <= 1'b0;
      end
    end
  end

  assign ram_re = sys_en & rd_active_q;

  r22sdf_dpram #(
    .depth (2 * fft_length),
    .width (dw)
  ) u_ram (
    .clk   (sys_clk),
    .rst_n (sys_nrst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata ({din_r, din_i}),
    .re    (ram_re),
    .raddr ({rd_bank_q, rd_cnt_q}),
    .rdata (ram_rdata)
  );

  // Tags travelling alongside the RAM read register.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      vld1_q <= 1'b0;
      sof1_q <= 1'b0;
      idx1_q <= '0;
    end else if (sys_en) begin
      vld1_q <= rd_active_q;
      sof1_q <= rd_active_q & (rd_cnt_q == '0);
      idx1_q <= rd_cnt_q;
    end
  end

  // Valid is masked with sys_en so a frozen cycle never repeats a bin.
  if (ff_out_en) begin : g_ff_out
    logic [dw-1:0] data2_q;
    logic          vld2_q, sof2_q;
    logic [aw-1:0] idx2_q;

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
        data2_q <= '0;
        vld2_q  <= 1'b0;
        sof2_q  <= 1'b0;
        idx2_q  <= '0;
      end else if (sys_en) begin
        data2_q <= ram_rdata;
        vld2_q  <= vld1_q;
        sof2_q  <= sof1_q;
        idx2_q  <= idx1_q;
      end
    end

    assign dout_r   = data2_q[dw-1:data_resolution];
    assign dout_i   = data2_q[data_resolution-1:0];
    assign dout_vld = vld2_q & sys_en;
    assign dout_sof = sof2_q;
    assign dout_idx = idx2_q;
  end else begin : g_ram_out
    assign dout_r   = ram_rdata[dw-1:data_resolution];
    assign dout_i   = ram_rdata[data_resolution-1:0];
    assign dout_vld = vld1_q & sys_en;
    assign dout_sof = sof1_q;
    assign dout_idx = idx1_q;
  end

`ifdef R22SDF_REORDER_ERR_EN
  logic       resync;
  logic       err_q;
  logic [7:0] err_cnt_q;

  assign resync = wr_acc & din_sof & (state_q != IDLE) & (wr_cnt_q != '0);

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (sys_en) begin
      err_q <= resync;
      if (resync && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_sof = err_q & sys_en;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_r22sdf_reorder.sv
// tb/tb_r22sdf_reorder.sv - directed self-checking bench for r22sdf_reorder
module tb_r22sdf_reorder;

  logic        sys_clk;
  logic        sys_nrst;
  logic        sys_en;
  logic [15:0] din_r, din_i;
  logic        din_vld, din_sof;
  logic [15:0] dout_r, dout_i;
  logic        dout_vld, dout_sof;
  logic [3:0]  dout_idx;
`ifdef R22SDF_REORDER_ERR_EN
  logic        err_sof;
  logic [7:0]  err_cnt;
`endif

  r22sdf_reorder #(
    .data_resolution (16),
    .fft_length      (16),
    .ff_out_en       (1'b1)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_nrst (sys_nrst),
    .sys_en   (sys_en),
    .din_r    (din_r),
    .din_i    (din_i),
    .din_vld  (din_vld),
    .din_sof  (din_sof),
    .dout_r   (dout_r),
    .dout_i   (dout_i),
    .dout_vld (dout_vld),
    .dout_sof (dout_sof),
    .dout_idx (dout_idx)
`ifdef R22SDF_REORDER_ERR_EN
    ,
    .err_sof  (err_sof),
    .err_cnt  (err_cnt)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dis_vld = 0;
  int err_pulses = 0;
  int last_wr = 0;
  int first_wr = 0;
  bit found;

  int          q_cyc[$];
  logic [15:0] q_r[$];
  logic [15:0] q_i[$];
  logic [3:0]  q_idx[$];
  logic        q_sof[$];

  function automatic logic [15:0] br4(input int p);
    logic [3:0] v;
    v = 4'(p);
    return {12'd0, v[0], v[1], v[2], v[3]};
  endfunction

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=0x%0h expected=0x%0h", tag, n, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_cyc.delete(); q_r.delete(); q_i.delete(); q_idx.delete(); q_sof.delete();
  endtask

  // One clock cycle: drive inputs at the falling edge, sample outputs 1 ns later.
  task automatic cycle(input logic en, input logic vld, input logic sof,
                       input logic [15:0] r, input logic [15:0] i);
    @(negedge sys_clk);
    sys_en = en; din_vld = vld; din_sof = sof; din_r = r; din_i = i;
    #1;
    if (dout_vld === 1'b1) begin
      q_cyc.push_back(cyc); q_r.push_back(dout_r); q_i.push_back(dout_i);
      q_idx.push_back(dout_idx); q_sof.push_back(dout_sof);
    end
    if (!en && dout_vld !== 1'b0) dis_vld++;
`ifdef R22SDF_REORDER_ERR_EN
    if (err_sof === 1'b1) err_pulses++;
`endif
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Sample at write position p carries value base + bitrev(p), so bin k = base + k.
  task automatic send_frame(input logic [15:0] rb, input logic [15:0] ib, input bit sof);
    for (int p = 0; p < 16; p++)
      cycle(1'b1, 1'b1, sof && (p == 0), rb + br4(p), ib + br4(p));
    last_wr = cyc - 1;
  endtask

  task automatic check_frame(input string tag, input int n, input logic [15:0] rb,
                             input logic [15:0] ib, input bit gapless);
    chk({tag, "_count"}, 0, q_r.size(), n);
    for (int j = 0; j < q_r.size() && j < n; j++) begin
      chk({tag, "_idx"}, j, 32'(q_idx[j]), j % 16);
      chk({tag, "_r"},   j, 32'(q_r[j]),   32'(rb + 16'(j)));
      chk({tag, "_i"},   j, 32'(q_i[j]),   32'(ib + 16'(j)));
      chk({tag, "_sof"}, j, 32'(q_sof[j]), ((j % 16) == 0) ? 1 : 0);
      if (gapless) chk({tag, "_gap"}, j, q_cyc[j], q_cyc[0] + j);
    end
  endtask

  initial begin
    sys_nrst = 1'b0; sys_en = 1'b0; din_vld = 1'b0; din_sof = 1'b0;
    din_r = '0; din_i = '0;
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_vld", 0, dout_vld, 0);
    chk("rst_sof", 0, dout_sof, 0);
    chk("rst_idx", 0, dout_idx, 0);
    chk("rst_r",   0, dout_r,   0);
    chk("rst_i",   0, dout_i,   0);
    sys_nrst = 1'b1;

    // Samples before any din_sof are dropped.
    clear_q();
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 16'h55, 16'h55);
    idle(30);
    chk("pre_sof_out", 0, q_r.size(), 0);

    // Single frame, bins 0..15, first output at t+3.
    clear_q();
    send_frame(16'h0000, 16'h0100, 1'b1);
    idle(25);
    check_frame("frame1", 16, 16'h0000, 16'h0100, 1'b1);
    if (q_cyc.size() > 0) chk("frame1_lat", 0, q_cyc[0], last_wr + 3);

    // Three back-to-back frames, one din_sof.
    clear_q();
    first_wr = cyc;
    for (int f = 0; f < 3; f++)
      send_frame(16'(f * 16), 16'(16'h1000 + f * 16), f == 0);
    idle(25);
    check_frame("three", 48, 16'h0000, 16'h1000, 1'b1);
    if (q_cyc.size() > 0) chk("three_lat", 0, q_cyc[0], first_wr + 18);

    // sys_en toggling; disabled cycles carry junk with din_sof set.
    clear_q();
    dis_vld = 0;
    for (int p = 0; p < 16; p++) begin
      cycle(1'b1, 1'b1, p == 0, 16'h0040 + br4(p), 16'h0140 + br4(p));
      cycle(1'b0, 1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
    end
    repeat (25) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    check_frame("toggle", 16, 16'h0040, 16'h0140, 1'b0);
    chk("toggle_dis_vld", 0, dis_vld, 0);

    // Mid-frame resync at wr_cnt = 5.
`ifdef R22SDF_REORDER_ERR_EN
    chk("err_before", 0, err_pulses, 0);
`endif
    clear_q();
    err_pulses = 0;
    for (int p = 0; p < 5; p++)
      cycle(1'b1, 1'b1, p == 0, 16'h0300 + br4(p), 16'h0300);
    send_frame(16'h0400, 16'h2400, 1'b1);
    idle(25);
    check_frame("resync", 16, 16'h0400, 16'h2400, 1'b1);
`ifdef R22SDF_REORDER_ERR_EN
    chk("err_pulses", 0, err_pulses, 1);
`endif

    // Reset during output bin 7.
    clear_q();
    send_frame(16'h0500, 16'h2500, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      if (dout_vld === 1'b1 && dout_idx === 4'd7) found = 1'b1;
    end
    chk("bin7_found", 0, found, 1);
    chk("bin7_r", 0, dout_r, 16'h0507);
    sys_nrst = 1'b0;
    #1;
    chk("arst_vld", 0, dout_vld, 0);
    chk("arst_sof", 0, dout_sof, 0);
    chk("arst_idx", 0, dout_idx, 0);
    chk("arst_r",   0, dout_r,   0);
    chk("arst_i",   0, dout_i,   0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    sys_nrst = 1'b1;
    clear_q();
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 16'h0077, 16'h0077);
    idle(30);
    chk("post_rst_out", 0, q_r.size(), 0);
    clear_q();
    send_frame(16'h0600, 16'h2600, 1'b1);
    idle(25);
    check_frame("after_rst", 16, 16'h0600, 16'h2600, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/r22sdf_reorder.md
# r22sdf_reorder

Natural-order output reorder buffer for the R2²SDF FFT pipeline. It sits directly after the last r22sdf_mod stage and consumes its bit-reversed-order output stream. It writes each frame into one bank of a ping-pong buffer at bit-reversed addresses while the other bank is read out in natural order. Output is one complex bin per enabled cycle, tagged with frame start, valid and bin index.

## Interface
- data_resolution, 16, width of each real/imag sample
- fft_length, 16, points per frame; power of 2, ≥4; AW = log2(fft_length)
- ff_out_en, 1, 1 = extra output register stage, 0 = outputs straight from the RAM read register
- sys_clk  in  1  single clock, rising edge
- sys_nrst  in  1  asynchronous active-low reset
- sys_en  in  1  global enable (the FFT's sys_en_glb); 0 freezes all state
- din_r, din_i  in  data_resolution  FFT output sample, bit-reversed order
- din_vld  in  1  sample valid
- din_sof  in  1  first sample of a frame; qualified by din_vld
- dout_r, dout_i  out  data_resolution  natural-order bin
- dout_vld  out  1  bin valid
- dout_sof  out  1  bin 0 of a frame
- dout_idx  out  AW  bin index k

## Operation
- Storage: 2 × fft_length words of {din_r, din_i}, bank select = 1 MSB. Synchronous write, synchronous read with 1-cycle latency.
- A write is accepted when sys_en & din_vld.
- Write FSM states:
  - IDLE: reset state; samples are dropped until din_sof. The sof sample is written to addr 0 of bank 0 -> FILL.
  - FILL: first frame being written.
  - STREAM: steady state.
- Write address = {wr_bank, bitrev(wr_cnt)}. wr_cnt increments per accepted write.
- At wr_cnt = fft_length−1:
  - wr_cnt wraps to 0 and wr_bank toggles.
  - The rd_start pulse fires for the completed bank.
  - FILL -> STREAM.
- Frames after the first need no din_sof; counting is continuous.
- din_sof with wr_cnt ≠ 0 (mid-frame resync):
  - The partial bank is discarded.
  - The sample is written at bitrev(0) of the same bank, and wr_cnt restarts at 1.
  - The read side is unaffected.
- din_sof with wr_cnt = 0: normal, no action.
- Read side:
  - rd_start loads rd_bank = completed bank, sets rd_cnt = 0 and rd_active = 1.
  - Each sys_en cycle while rd_active: read addr {rd_bank, rd_cnt}, rd_cnt++.
  - rd_active clears after rd_cnt = fft_length−1.
- No overrun is possible: the read drains a bank in exactly fft_length enabled cycles, and the writer needs ≥ fft_length accepted writes before it returns to that bank.
- If rd_start and the last read of the previous bank coincide, the new bank starts on the next cycle with no gap.
- Output fields are pipelined alongside the read data: dout_sof = (rd_cnt == 0), dout_idx = rd_cnt.
- dout_vld = internal valid register & sys_en, so a frozen cycle never presents a duplicate bin.
- Reset values: dout_r = dout_i = 0, dout_vld = 0, dout_sof = 0, dout_idx = 0, FSM = IDLE, all counters 0, rd_active = 0.
- Data passes unmodified; no arithmetic, no width change.

## Timing
- Let the last accepted write of a frame occur at cycle t (all cycles enabled).
- Bin 0 appears with dout_vld = 1 and dout_sof = 1 at t + 2 + ff_out_en.
- Bin k appears at t + 2 + ff_out_en + k.
- With a gapless input, output is gapless, and frame latency = fft_length + 1 + ff_out_en cycles (first input to first output).
- sys_en = 0 cycle: no register updates, no RAM write, dout_vld = 0. Operation resumes seamlessly on the next enabled cycle.
- Reset asserted mid-frame: all outputs reach reset values immediately (async). Buffered data is abandoned, and a din_sof is required after release.

## Configuration
- Macro: R22SDF_REORDER_ERR_EN.
- Defined: adds output port err_sof (1 bit, reset 0).
  - Registered one-cycle pulse when a din_sof is accepted with wr_cnt ≠ 0 in FILL or STREAM.
  - Also adds a saturating 8-bit resync counter readable as err_cnt, reset 0.
- Undefined: neither port exists; resync behaviour is identical.

## Structure
- Shared package r22sdf_pkg holds:
  - the bit-reverse function bitrev(value, AW)
  - the write FSM state typedef (IDLE, FILL, STREAM)
  - the clog2 helper constant function
- One sub-module, r22sdf_dpram: simple dual-port RAM, 1 write port, 1 registered read port, parameterised depth and width.

## Test plan
- Reset, then a 16-pt frame with din_sof, input values x[n] = n written in bit-reversed order (0, 8, 4, 12, …). Expected response:
  - dout_idx 0..15 with dout_r = 0..15.
  - dout_sof only at idx 0.
  - First dout_vld at t+3 (ff_out_en = 1).
- Three back-to-back frames, single din_sof at the start. Expected response:
  - 48 consecutive dout_vld cycles, no gaps.
  - dout_sof at output cycles 0, 16 and 32.
- sys_en toggled 1/0 every other cycle through a full frame. Expected response:
  - Same 16 bins in order, no duplicates.
  - dout_vld = 0 on every disabled cycle.
- din_sof at wr_cnt = 5, then a full frame. Expected response:
  - The partial frame never appears on the output.
  - The next output frame equals the new frame.
  - err_sof pulses once when R22SDF_REORDER_ERR_EN is defined.
- Samples with din_vld = 1 before any din_sof: no RAM writes, dout_vld stays 0.
- sys_nrst asserted during output bin 7: outputs are 0 immediately. After release, no output until a new din_sof frame completes.
